// File: rtl/relu_row_sched.sv
// relu_row_sched: streams rows from the output buffer through per-lane ReLU
// (or identity) into the next-layer buffer, one row per RD/CAP/WR cycle.
// Ports: clk, reset (sync, active-high), start/num_rows/relu_en/src_base/
//   dst_base (pass config, sampled in IDLE), rd_en/rd_addr/rd_data (source
//   buffer, one-cycle read latency), wr_en/wr_addr/wr_data/wr_ready (dest
//   buffer with back-pressure), busy, done (one-cycle end-of-pass pulse).
// Option: define RELU_CLAMP_EN to clamp positive ReLU lanes at CLAMP_MAX.
module relu_row_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int NO_RELU    = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CLAMP_MAX  = 127
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH:0]           num_rows,
    input  logic                          relu_en,
    input  logic [ADDR_WIDTH-1:0]         src_base,
    input  logic [ADDR_WIDTH-1:0]         dst_base,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [DATA_WIDTH*NO_RELU-1:0] rd_data,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH*NO_RELU-1:0] wr_data,
    input  logic                          wr_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int W = DATA_WIDTH * NO_RELU;

    if (CLAMP_MAX < 1 || CLAMP_MAX > (2 ** (DATA_WIDTH - 1)) - 1) begin : g_bad_clamp
        $error("CLAMP_MAX out of range for DATA_WIDTH");
    end

`ifdef RELU_CLAMP_EN
    localparam logic signed [DATA_WIDTH-1:0] CMAX = DATA_WIDTH'(CLAMP_MAX);
`endif

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   rows_q;
    logic [ADDR_WIDTH:0]   row_idx;
    logic                  relu_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic                  last_row;
    logic [W-1:0]          act_row;

    function automatic logic [DATA_WIDTH-1:0] act_lane(
        input logic [DATA_WIDTH-1:0] x,
        input logic                  en
    );
        logic signed [DATA_WIDTH-1:0] s;
        s = x;
        if (!en) return x;
        // Negative or zero lanes map to zero
        if (s[DATA_WIDTH-1] || s == '0) return '0;
`ifdef RELU_CLAMP_EN
        if (s > CMAX) return CMAX;
`endif
        return x;
    endfunction

    always_comb begin
        act_row = '0;
        for (int i = 0; i < NO_RELU; i++) begin
            act_row[i*DATA_WIDTH +: DATA_WIDTH] =
                act_lane(rd_data[i*DATA_WIDTH +: DATA_WIDTH], relu_q);
        end
    end

    // rows_q is nonzero whenever the FSM is in WR
    assign last_row = (row_idx == rows_q - 1'b1);

    // Addresses wrap modulo 2^ADDR_WIDTH by truncation
    assign rd_addr = src_q + row_idx[ADDR_WIDTH-1:0];
    assign wr_addr = dst_q + row_idx[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (num_rows == '0) ? DONE : RD;
            end
            RD: begin
                rd_en     = 1'b1;
                state_nxt = CAP;
            end
            CAP: state_nxt = WR;
            WR: begin
                wr_en = 1'b1;
                if (wr_ready) state_nxt = last_row ? DONE : RD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_q  <= '0;
            row_idx <= '0;
            relu_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            wr_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rows_q  <= num_rows;
                        relu_q  <= relu_en;
                        src_q   <= src_base;
                        dst_q   <= dst_base;
                        row_idx <= '0;
                    end
                end
                CAP: wr_data <= act_row;
                WR: begin
                    if (wr_ready && !last_row) row_idx <= row_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_row_sched.sv
// tb_relu_row_sched: randomized self-checking bench for relu_row_sched
// against a row-level reference model of the activation pass.
module tb_relu_row_sched;

    localparam int DW = 8;
    localparam int NL = 8;
    localparam int AW = 6;
    localparam int W  = DW * NL;
`ifdef RELU_CLAMP_EN
    localparam int CM = 6;
`else
    localparam int CM = 127;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW:0]   num_rows;
    logic          relu_en;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          wr_ready;
    logic          busy;
    logic          done;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] src_mem [64];

    int           exp_rd [$];
    int           exp_wa [$];
    logic [W-1:0] exp_wd [$];

    int           rd_log [$];
    int           wa_log [$];
    logic [W-1:0] wd_log [$];
    int done_cyc, done_cnt, stalls, hold_bad, busy_bad, busy_after;
    int timeout, zero_bad;

    relu_row_sched #(
        .DATA_WIDTH(DW), .NO_RELU(NL), .ADDR_WIDTH(AW), .CLAMP_MAX(CM)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .relu_en(relu_en), .src_base(src_base), .dst_base(dst_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Source buffer: data one cycle after the read strobe, junk otherwise
    always @(posedge clk) begin
        if (rd_en) rd_data <= src_mem[rd_addr];
        else       rd_data <= {$urandom, $urandom};
    end

    function automatic logic [W-1:0] pack(input int l [NL]);
        logic [W-1:0] r;
        int v;
        for (int i = 0; i < NL; i++) begin
            v = l[i];
            r[i*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] act_row(input logic [W-1:0] r, input bit relu);
        logic [W-1:0] o;
        int v;
        for (int i = 0; i < NL; i++) begin
            v = $signed(r[i*DW +: DW]);
            if (relu) begin
                if (v < 0) v = 0;
`ifdef RELU_CLAMP_EN
                if (v > CM) v = CM;
`endif
            end
            o[i*DW +: DW] = v[DW-1:0];
        end
        return o;
    endfunction

    task automatic model_pass(input int n, input bit relu, input int src, input int dst);
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        for (int r = 0; r < n; r++) begin
            exp_rd.push_back((src + r) % 64);
            exp_wa.push_back((dst + r) % 64);
            exp_wd.push_back(act_row(src_mem[(src + r) % 64], relu));
        end
    endtask

    // Drives one pass starting at #1 after a posedge in IDLE; records what
    // the DUT does, cycle c = 1 being the first cycle after start is sampled.
    task automatic run_pass(input int n, input bit relu, input int src, input int dst,
                            input int first_stall, input bit rnd_stall,
                            input int abort_at, input bit pulse_wr);
        int fs;
        bit hs_seen, prev_stall, pulsed;
        int pa;
        logic [W-1:0] pd;
        fs = first_stall;
        hs_seen = 0; prev_stall = 0; pulsed = 0; pa = 0; pd = '0;
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        done_cyc = -1; done_cnt = 0; stalls = 0; hold_bad = 0; busy_bad = 0;
        busy_after = 1; timeout = 0; zero_bad = 0;
        start = 1;
        num_rows = (AW+1)'(n);
        relu_en = relu;
        src_base = AW'(src);
        dst_base = AW'(dst);
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            start = 0;
            num_rows = (AW+1)'($urandom);
            relu_en = 1'($urandom);
            src_base = AW'($urandom);
            dst_base = AW'($urandom);
            if (abort_at > 0 && c == abort_at + 1) begin
                reset = 0;
                if (rd_en || wr_en || busy || done || rd_addr != 0 ||
                    wr_addr != 0 || wr_data != 0) zero_bad++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if ((done_cyc < 0 || done_cyc == c) && (abort_at == 0 || c <= abort_at) && !busy)
                busy_bad++;
            if (rd_en) rd_log.push_back(int'(rd_addr));
            if (wr_en) begin
                if (prev_stall && (int'(wr_addr) != pa || wr_data != pd)) hold_bad++;
                if (!hs_seen && fs > 0) begin
                    wr_ready = 0;
                    fs--;
                end else if (rnd_stall) begin
                    wr_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    wr_ready = 1;
                end
            end else begin
                wr_ready = 1'($urandom_range(0, 1));
            end
            prev_stall = wr_en && !wr_ready;
            pa = int'(wr_addr);
            pd = wr_data;
            if (wr_en && !wr_ready) stalls++;
            if (wr_en && wr_ready) begin
                wa_log.push_back(int'(wr_addr));
                wd_log.push_back(wr_data);
                hs_seen = 1;
            end
            if (pulse_wr && wr_en && !pulsed) begin
                start = 1;
                pulsed = 1;
            end
            if (abort_at > 0 && c == abort_at) reset = 1;
            if (abort_at > 0 && c == abort_at + 3) break;
            if (abort_at == 0 && done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            if (c == 400) timeout = 1;
        end
        start = 0;
        wr_ready = 1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({rd_en, wr_en, busy, done} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0000", {rd_en, wr_en, busy, done});
        end
        vectors++;
        if (rd_addr !== '0 || wr_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: got rd=%0d wr=%0d want 0 0", rd_addr, wr_addr);
        end
        vectors++;
        if (wr_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", wr_data);
        end
    endtask

    task automatic test_relu_basic();
        int lanes [NL] = '{-3, 0, 5, 127, -128, 1, -1, 64};
        int want  [NL] = '{0, 0, 5, 127, 0, 1, 0, 64};
        src_mem[4] = pack(lanes);
        model_pass(2, 1, 4, 10);
        run_pass(2, 1, 4, 10, 0, 0, 0, 0);
        vectors++;
        if (rd_log.size() != 2 || wa_log.size() != 2) begin
            miscompares++;
            $display("FAIL basic_count: got rd=%0d wr=%0d want 2 2", rd_log.size(), wa_log.size());
        end
        for (int i = 0; i < rd_log.size() && i < 2; i++) begin
            vectors++;
            if (rd_log[i] != exp_rd[i] || wa_log.size() <= i ||
                wa_log[i] != exp_wa[i] || wd_log[i] !== exp_wd[i]) begin
                miscompares++;
                $display("FAIL basic_row%0d: got rd=%0d wa=%0d wd=%h want rd=%0d wa=%0d wd=%h",
                         i, rd_log[i], (wa_log.size() > i) ? wa_log[i] : -1,
                         (wd_log.size() > i) ? wd_log[i] : '0,
                         exp_rd[i], exp_wa[i], exp_wd[i]);
            end
        end
`ifndef RELU_CLAMP_EN
        vectors++;
        if (wd_log.size() < 1 || wd_log[0] !== pack(want)) begin
            miscompares++;
            $display("FAIL basic_lanes: got %h want %h",
                     (wd_log.size() > 0) ? wd_log[0] : '0, pack(want));
        end
`endif
        vectors++;
        if (done_cyc != 7 || busy_after != 0 || busy_bad != 0) begin
            miscompares++;
            $display("FAIL basic_timing: got done=%0d busy_after=%0d busy_bad=%0d want 7 0 0",
                     done_cyc, busy_after, busy_bad);
        end
    endtask

    task automatic test_bypass();
        int lanes [NL] = '{-3, 0, 5, 127, -128, 1, -1, 64};
        src_mem[4] = pack(lanes);
        model_pass(2, 0, 4, 10);
        run_pass(2, 0, 4, 10, 0, 0, 0, 0);
        vectors++;
        if (wd_log.size() != 2 || wd_log[0] !== pack(lanes) || wd_log[1] !== exp_wd[1]) begin
            miscompares++;
            $display("FAIL bypass_data: got n=%0d row0=%h want n=2 row0=%h",
                     wd_log.size(), (wd_log.size() > 0) ? wd_log[0] : '0, pack(lanes));
        end
        vectors++;
        if (done_cyc != 7) begin
            miscompares++;
            $display("FAIL bypass_done: got %0d want 7", done_cyc);
        end
    endtask

    task automatic test_back_pressure();
        model_pass(2, 1, 4, 10);
        run_pass(2, 1, 4, 10, 4, 0, 0, 0);
        vectors++;
        if (hold_bad != 0 || stalls != 4) begin
            miscompares++;
            $display("FAIL bp_hold: got hold_bad=%0d stalls=%0d want 0 4", hold_bad, stalls);
        end
        vectors++;
        if (done_cyc != 11) begin
            miscompares++;
            $display("FAIL bp_done: got %0d want 11", done_cyc);
        end
        vectors++;
        if (wd_log.size() != 2 || wd_log[0] !== exp_wd[0] || wa_log[0] != exp_wa[0]) begin
            miscompares++;
            $display("FAIL bp_write: got n=%0d want 2 with addr %0d", wd_log.size(), exp_wa[0]);
        end
    endtask

    task automatic test_zero_and_wrap();
        run_pass(0, 1, 7, 9, 0, 0, 0, 0);
        vectors++;
        if (done_cyc != 1 || rd_log.size() != 0 || wa_log.size() != 0 || busy_after != 0) begin
            miscompares++;
            $display("FAIL zero_rows: got done=%0d rd=%0d wr=%0d busy=%0d want 1 0 0 0",
                     done_cyc, rd_log.size(), wa_log.size(), busy_after);
        end
        model_pass(2, 1, 63, 63);
        run_pass(2, 1, 63, 63, 0, 0, 0, 0);
        vectors++;
        if (rd_log.size() != 2 || rd_log[0] != 63 || rd_log[1] != 0) begin
            miscompares++;
            $display("FAIL wrap_rd: got %p want 63 0", rd_log);
        end
        vectors++;
        if (wa_log.size() != 2 || wa_log[1] != 0 || wd_log[1] !== exp_wd[1]) begin
            miscompares++;
            $display("FAIL wrap_wr: got %p want 63 0", wa_log);
        end
    endtask

    task automatic test_reset_mid_pass();
        run_pass(3, 1, 20, 30, 0, 0, 5, 0);
        vectors++;
        if (zero_bad != 0 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL abort: got zero_bad=%0d done_cnt=%0d want 0 0", zero_bad, done_cnt);
        end
        vectors++;
        if (rd_log.size() != 2 || wa_log.size() != 1) begin
            miscompares++;
            $display("FAIL abort_progress: got rd=%0d wr=%0d want 2 1", rd_log.size(), wa_log.size());
        end
        model_pass(3, 1, 20, 30);
        run_pass(3, 1, 20, 30, 0, 0, 0, 0);
        vectors++;
        if (done_cyc != 10 || wd_log.size() != 3 || wd_log[2] !== exp_wd[2] || wa_log[0] != 30) begin
            miscompares++;
            $display("FAIL after_abort: got done=%0d n=%0d want 10 3", done_cyc, wd_log.size());
        end
    endtask

    task automatic test_start_while_busy();
        model_pass(3, 0, 50, 2);
        run_pass(3, 0, 50, 2, 0, 0, 0, 1);
        vectors++;
        if (done_cyc != 10 || done_cnt != 1 || rd_log.size() != 3) begin
            miscompares++;
            $display("FAIL busy_start: got done=%0d cnt=%0d rd=%0d want 10 1 3",
                     done_cyc, done_cnt, rd_log.size());
        end
        vectors++;
        if (wd_log.size() != 3 || wd_log[1] !== exp_wd[1] || wa_log[2] != exp_wa[2]) begin
            miscompares++;
            $display("FAIL busy_start_data: got n=%0d want 3", wd_log.size());
        end
    endtask

    task automatic test_clamp();
        int lanes [NL] = '{7, 6, 5, -2, 100, 0, 1, 127};
`ifdef RELU_CLAMP_EN
        int want  [NL] = '{6, 6, 5, 0, 6, 0, 1, 6};
`else
        int want  [NL] = '{7, 6, 5, 0, 100, 0, 1, 127};
`endif
        src_mem[40] = pack(lanes);
        run_pass(1, 1, 40, 41, 0, 0, 0, 0);
        vectors++;
        if (wd_log.size() != 1 || wd_log[0] !== pack(want)) begin
            miscompares++;
            $display("FAIL clamp: got %h want %h",
                     (wd_log.size() > 0) ? wd_log[0] : '0, pack(want));
        end
    endtask

    task automatic test_random();
        int n, s, d, bad;
        bit relu;
        for (int p = 0; p < 20; p++) begin
            n = (p == 7) ? 64 : $urandom_range(0, 12);
            s = $urandom_range(0, 63);
            d = $urandom_range(0, 63);
            relu = 1'($urandom);
            model_pass(n, relu, s, d);
            run_pass(n, relu, s, d, 0, 1, 0, 0);
            bad = 0;
            if (rd_log.size() != n || wa_log.size() != n) bad++;
            for (int i = 0; i < n && i < rd_log.size() && i < wa_log.size(); i++) begin
                if (rd_log[i] != exp_rd[i] || wa_log[i] != exp_wa[i] || wd_log[i] !== exp_wd[i])
                    bad++;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL rand%0d_rows: got %0d bad rows (n=%0d rd=%0d wr=%0d)",
                         p, bad, n, rd_log.size(), wa_log.size());
            end
            vectors++;
            if (done_cyc != ((n == 0) ? 1 : 3 * n + 1 + stalls) || timeout != 0) begin
                miscompares++;
                $display("FAIL rand%0d_done: got %0d want %0d", p, done_cyc,
                         (n == 0) ? 1 : 3 * n + 1 + stalls);
            end
            vectors++;
            if (hold_bad != 0 || busy_bad != 0 || busy_after != 0) begin
                miscompares++;
                $display("FAIL rand%0d_ctl: got hold=%0d busy_bad=%0d busy_after=%0d want 0 0 0",
                         p, hold_bad, busy_bad, busy_after);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        clk = 0;
        reset = 1;
        start = 0;
        num_rows = '0;
        relu_en = 0;
        src_base = '0;
        dst_base = '0;
        wr_ready = 1;
        for (int i = 0; i < 64; i++) src_mem[i] = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 0;
        @(posedge clk);
        #1;
        test_relu_basic();
        test_bypass();
        test_back_pressure();
        test_zero_and_wrap();
        test_reset_mid_pass();
        test_start_while_busy();
        test_clamp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/relu_row_sched.md
# relu_row_sched

Sequencer for the post-accumulation activation stage. It streams `num_rows` packed rows of `NO_RELU` signed lanes from the output buffer, applies per-lane ReLU (or bypass), and writes each row to the next-layer buffer. A single start/done pair, issued by the layer controller, brackets one layer pass. Transfers are one row at a time with write back-pressure.

## Interface
- `DATA_WIDTH`, 8, width of one signed lane
- `NO_RELU`, 8, lanes per row; row width `W = DATA_WIDTH*NO_RELU`
- `ADDR_WIDTH`, 6, buffer address width
- `CLAMP_MAX`, 127, upper clamp for positive lanes (used only with `RELU_CLAMP_EN`)
- `clk`  in  1  single clock; all logic rising-edge
- `reset`  in  1  synchronous, active-high; sampled on `clk`
- `start`  in  1  begin a pass; sampled only in IDLE
- `num_rows`  in  ADDR_WIDTH+1  rows to process (0 to 2^ADDR_WIDTH), sampled with `start`
- `relu_en`  in  1  1 = apply ReLU, 0 = identity; sampled with `start`
- `src_base`  in  ADDR_WIDTH  first read address, sampled with `start`
- `dst_base`  in  ADDR_WIDTH  first write address, sampled with `start`
- `rd_en`  out  1  read strobe to source buffer
- `rd_addr`  out  ADDR_WIDTH  read address
- `rd_data`  in  W  read data, valid exactly one cycle after `rd_en`
- `wr_en`  out  1  write request to destination buffer
- `wr_addr`  out  ADDR_WIDTH  write address
- `wr_data`  out  W  activated row
- `wr_ready`  in  1  destination accepts; handshake = `wr_en && wr_ready`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of pass

## Operation
- FSM states: IDLE, RD, CAP, WR, DONE.
- IDLE: when `start`=1, latch `num_rows`, `relu_en`, `src_base` and `dst_base`, then clear `row_idx`. Go to DONE if `num_rows`=0, else go to RD.
- RD: `rd_en`=1, `rd_addr = src_base + row_idx`. Next state is CAP.
- CAP: capture `rd_data` through the lane function into the `wr_data` register. Next state is WR.
- WR: `wr_en`=1, `wr_addr = dst_base + row_idx`. Hold `wr_data`, `wr_addr` and `wr_en` stable until handshake.
  - On handshake with `row_idx == num_rows-1`: go to DONE.
  - On any other handshake: increment `row_idx` and go to RD.
- DONE: `done`=1 for exactly one cycle. Next state is IDLE.
- Lane function applies per lane i on signed `rd_data[i*DATA_WIDTH +: DATA_WIDTH]`:
  - `relu_en`=1: output is the lane if lane > 0, else 0 (zero maps to 0).
  - `relu_en`=0: output is the lane unchanged, including negatives.
- Address arithmetic is modulo 2^ADDR_WIDTH; base + index wraps silently.
- `start` while busy is ignored. Latched configuration does not change mid-pass.
- Input changes on `num_rows`, `relu_en`, `src_base` and `dst_base` outside IDLE have no effect.
- Reset, including mid-pass:
  - Next state is IDLE.
  - `rd_en`, `wr_en`, `busy` and `done` = 0.
  - `rd_addr`, `wr_addr` and `wr_data` = 0; `row_idx` = 0.
  - No `done` pulse is produced for an aborted pass.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from an input to an output.
- Start sampled at cycle T:
  - `busy`=1 from T+1.
  - First `rd_en` at T+1.
  - `wr_en` first high at T+3.
- Each row takes 3 cycles (RD, CAP, WR) when `wr_ready`=1, plus one cycle per stalled WR cycle.
- With `wr_ready` held high, N rows give `done` at T+3N+1 and `busy` low at T+3N+2.
- `num_rows`=0 gives `done` at T+1 and no `rd_en`/`wr_en` ever.
- `wr_ready` asserted outside WR has no effect.

## Configuration
- `RELU_CLAMP_EN` defined: in ReLU mode, positive lanes greater than `CLAMP_MAX` output `CLAMP_MAX`, giving a bounded ReLU.
  - Identity mode is unaffected.
  - `CLAMP_MAX` must be positive and no more than 2^(DATA_WIDTH-1)-1.
- `RELU_CLAMP_EN` undefined: plain ReLU, `CLAMP_MAX` ignored, no comparator logic synthesized.

## Test plan
- Basic ReLU pass:
  - Stimulus: `num_rows`=2, `relu_en`=1, `src_base`=4, `dst_base`=10, `wr_ready`=1; row 4 lanes = {-3,0,5,127,-128,1,-1,64}.
  - Response: reads at addresses 4 and 5; write to 10 with {0,0,5,127,0,1,0,64}; write to 11; `done` at T+7.
- Bypass:
  - Stimulus: same row with `relu_en`=0.
  - Response: written row equals input, including -3, -128 and -1.
- Back-pressure:
  - Stimulus: `wr_ready` low for 4 cycles in the first WR.
  - Response: `wr_en`, `wr_addr` and `wr_data` held constant; `done` delayed by exactly 4 cycles.
- Zero rows and wrap:
  - Stimulus A: `num_rows`=0. Response: `done` at T+1, no `rd_en`.
  - Stimulus B: `src_base`=63, `num_rows`=2 (ADDR_WIDTH=6). Response: reads at 63 then 0.
- Reset mid-pass and start while busy:
  - Stimulus: `reset` in CAP of row 1; separately, `start` pulsed during WR.
  - Response: reset returns all outputs to 0 next cycle with no `done`; a new `start` then runs normally. The pulse during WR is ignored.
- Clamp:
  - Stimulus: `RELU_CLAMP_EN` defined, `CLAMP_MAX`=6; lanes {7,6,5,-2,100,0,1,127}.
  - Response: {6,6,5,0,6,0,1,6}.
  - Without the macro, the same lanes give {7,6,5,0,100,0,1,127}.
